// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the dual-write register file and its busy scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   REG_ZERO                : address of the hardwired-zero register
//   PORT4_WINS              : when both write ports hit the same register in
//                             one cycle, port 4 (load writeback) is kept
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;

    // The load result is the younger producer, so it overrides the ALU result.
    localparam bit PORT4_WINS = 1'b1;

endpackage : reg_file_pkg

// File: rtl/reg_file_2w_if.sv
// -----------------------------------------------------------------------------
// reg_file_2w_if
// Bundles the read, write and issue signals of the dual-write register file.
//   master : decode / writeback side (drives addresses, data, enables, issue)
//   slave  : register file side (returns read data and busy flags)
// Signals:
//   A1, A2        read addresses          RD1, RD2     read data
//   BUSY1, BUSY2  pending-producer flags
//   WE3, A3, WD3  ALU writeback port      WE4, A4, WD4 load writeback port
//   ISS, ISS_A    issue strobe and destination register
// -----------------------------------------------------------------------------
interface reg_file_2w_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              BUSY1;
    logic              BUSY2;

    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;

    logic              WE4;
    logic [ADDR_W-1:0] A4;
    logic [DATA_W-1:0] WD4;

    logic              ISS;
    logic [ADDR_W-1:0] ISS_A;

    modport master (
        output A1, A2, WE3, A3, WD3, WE4, A4, WD4, ISS, ISS_A,
        input  RD1, RD2, BUSY1, BUSY2
    );

    modport slave (
        input  A1, A2, WE3, A3, WD3, WE4, A4, WD4, ISS, ISS_A,
        output RD1, RD2, BUSY1, BUSY2
    );

endinterface : reg_file_2w_if

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per register, marking registers whose producer has issued but
// not yet written back. Decode reads two flags to detect RAW hazards.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears all bits)
//   iss, iss_a      issue strobe and destination: sets busy[iss_a]
//   we3, a3         ALU writeback: clears busy[a3]
//   we4, a4         load writeback: clears busy[a4]
//   a1, a2          read addresses
//   busy1, busy2    busy[a1], busy[a2] (combinational)
// Optional: REG_FILE_BYPASS_EN makes a same-cycle write (without a same-cycle
// issue to that register) read as not busy.
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_a,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] a4,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    // Register 0 can never become busy.
    localparam logic [DEPTH-1:0] LIVE_MASK = ~(DEPTH'(1) << REG_ZERO);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] busy_next;

    always_comb begin
        set_mask = iss ? (DEPTH'(1) << iss_a) : '0;
        clr_mask = (we3 ? (DEPTH'(1) << a3) : '0) | (we4 ? (DEPTH'(1) << a4) : '0);
        // Set is applied after clear: a new producer issued in the same cycle
        // as the old one writes back keeps the register busy.
        busy_next = ((busy & ~clr_mask) | set_mask) & LIVE_MASK;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        // NOTE: outputs get a default first so no path leaves them unassigned,
        // which would otherwise infer a latch.
        busy1 = busy[a1];
        busy2 = busy[a2];
`ifdef REG_FILE_BYPASS_EN
        if (clr_mask[a1] && !set_mask[a1]) busy1 = 1'b0;
        if (clr_mask[a2] && !set_mask[a2]) busy2 = 1'b0;
`endif
    end

endmodule : reg_scoreboard

// File: rtl/reg_file_2w.sv
// -----------------------------------------------------------------------------
// reg_file_2w
// 2-read / 2-write register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero; writes to it are dropped.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset: registers -> RESET_VAL, busy -> 0
//   bus    reg_file_2w_if.slave: combinational reads (RD1/RD2, BUSY1/BUSY2),
//          clocked writes on ports 3 (ALU) and 4 (load), issue strobe
// Parameters: DATA_W, ADDR_W (depth = 2**ADDR_W), RESET_VAL.
// Optional: REG_FILE_BYPASS_EN forwards same-cycle write data to the read
// ports (port 4 before port 3) and hides busy for same-cycle writebacks.
// -----------------------------------------------------------------------------
module reg_file_2w
    import reg_file_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic         clk,
    input logic         reset,
    reg_file_2w_if.slave bus
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];

    logic wr3;
    logic wr4;

    assign wr3 = bus.WE3 && (bus.A3 != ZERO_A);
    assign wr4 = bus.WE4 && (bus.A4 != ZERO_A);

    // NOTE: the whole array is reset asynchronously because reset must clear
    // every register immediately; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (PORT4_WINS) begin
            // Later non-blocking assignment to the same entry takes effect.
            if (wr3) regs[bus.A3] <= bus.WD3;
            if (wr4) regs[bus.A4] <= bus.WD4;
        end else begin
            if (wr4) regs[bus.A4] <= bus.WD4;
            if (wr3) regs[bus.A3] <= bus.WD3;
        end
    end

    always_comb begin
        bus.RD1 = (bus.A1 == ZERO_A) ? '0 : regs[bus.A1];
`ifdef REG_FILE_BYPASS_EN
        if (bus.A1 != ZERO_A) begin
            if (bus.WE4 && bus.A4 == bus.A1) begin
                bus.RD1 = bus.WD4;
            end else if (bus.WE3 && bus.A3 == bus.A1) begin
                bus.RD1 = bus.WD3;
            end
        end
`endif
    end

    always_comb begin
        bus.RD2 = (bus.A2 == ZERO_A) ? '0 : regs[bus.A2];
`ifdef REG_FILE_BYPASS_EN
        if (bus.A2 != ZERO_A) begin
            if (bus.WE4 && bus.A4 == bus.A2) begin
                bus.RD2 = bus.WD4;
            end else if (bus.WE3 && bus.A3 == bus.A2) begin
                bus.RD2 = bus.WD3;
            end
        end
`endif
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .iss   (bus.ISS),
        .iss_a (bus.ISS_A),
        .we3   (bus.WE3),
        .a3    (bus.A3),
        .we4   (bus.WE4),
        .a4    (bus.A4),
        .a1    (bus.A1),
        .a2    (bus.A2),
        .busy1 (bus.BUSY1),
        .busy2 (bus.BUSY2)
    );

endmodule : reg_file_2w

// File: tb/tb_reg_file_2w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2w
// Self-checking bench for reg_file_2w. A behavioural model (plain arrays of
// register contents and busy flags) is updated on every clock edge from the
// architectural rules; a compare process checks all four outputs against it
// on every falling edge. Directed steps add literal expectations, then a
// randomized phase with occasional asynchronous reset pulses follows.
// Honours REG_FILE_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_reg_file_2w;
    import reg_file_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;

    reg_file_2w_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_2w #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .RESET_VAL ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (BYP && bus.WE4 && bus.A4 == a) return bus.WD4;
        if (BYP && bus.WE3 && bus.A3 == a) return bus.WD3;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        bit wr_hit;
        wr_hit = (bus.WE3 && bus.A3 == a) || (bus.WE4 && bus.A4 == a);
        if (a == '0) return 1'b0;
        if (BYP && wr_hit && !(bus.ISS && bus.ISS_A == a)) return 1'b0;
        return m_busy[a];
    endfunction

    // Architectural update at the clock edge: writes land (port 4 applied
    // last so it wins), writebacks retire their producer, then a new issue
    // marks its destination busy.
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.WE3 && bus.A3 != '0) begin
                m_regs[bus.A3] = bus.WD3;
                m_busy[bus.A3] = 1'b0;
            end
            if (bus.WE4 && bus.A4 != '0) begin
                m_regs[bus.A4] = bus.WD4;
                m_busy[bus.A4] = 1'b0;
            end
            if (bus.ISS && bus.ISS_A != '0) m_busy[bus.ISS_A] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("rd1_model",   bus.RD1, exp_rd(bus.A1));
        check("rd2_model",   bus.RD2, exp_rd(bus.A2));
        check("busy1_model", DW'(bus.BUSY1), DW'(exp_busy(bus.A1)));
        check("busy2_model", DW'(bus.BUSY2), DW'(exp_busy(bus.A2)));
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 2 time units after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.WE3 = 1'b0;
        bus.WE4 = 1'b0;
        bus.ISS = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        reset = 1'b1;
        clear_model();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_model();
        bus.A1 = '0; bus.A2 = '0;
        bus.WE3 = 1'b0; bus.A3 = '0; bus.WD3 = '0;
        bus.WE4 = 1'b0; bus.A4 = '0; bus.WD4 = '0;
        bus.ISS = 1'b0; bus.ISS_A = '0;

        // Reset held across an edge with a write and an issue pending:
        // reset dominates both.
        cycle();
        bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'hAAAA_5555;
        bus.ISS = 1'b1; bus.ISS_A = 5'd9; bus.A1 = 5'd9;
        cycle();
        #1;
        check("reset_dominates_rd1",   bus.RD1, 32'h0);
        check("reset_dominates_busy1", DW'(bus.BUSY1), 32'h0);
        idle();
        reset = 1'b0;

        // Preload reg5 with a pending producer, then reset mid-cycle.
        cycle();
        bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hDEAD_BEEF;
        bus.ISS = 1'b1; bus.ISS_A = 5'd5; bus.A1 = 5'd5;
        cycle();
        idle();
        #1;
        check("preload_rd1",   bus.RD1, 32'hDEAD_BEEF);
        check("preload_busy1", DW'(bus.BUSY1), 32'h1);
        reset = 1'b1;
        clear_model();
        #1;
        check("async_reset_rd1",   bus.RD1, 32'h0);
        check("async_reset_busy1", DW'(bus.BUSY1), 32'h0);
        reset = 1'b0;

        // Single write, then a disabled write port with live address/data.
        cycle();
        bus.WE3 = 1'b1; bus.A3 = 5'd2; bus.WD3 = 32'd9;
        cycle();
        bus.WE3 = 1'b0; bus.A3 = 5'd6; bus.WD3 = 32'd6;
        bus.A1 = 5'd2; bus.A2 = 5'd6;
        #1;
        check("single_write_rd1", bus.RD1, 32'd9);
        check("we_low_rd2",       bus.RD2, 32'd0);
        cycle();
        check("we_low_rd2_after", bus.RD2, 32'd0);

        // Writes to register 0 are discarded.
        bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'h1234; bus.A1 = 5'd0;
        #1;
        check("zero_reg_same_cycle", bus.RD1, 32'h0);
        cycle();
        check("zero_reg_after_1", bus.RD1, 32'h0);
        idle();
        cycle();
        check("zero_reg_after_2", bus.RD1, 32'h0);

        // Same-address collision: port 4 wins.
        bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WD3 = 32'h11;
        bus.WE4 = 1'b1; bus.A4 = 5'd7; bus.WD4 = 32'h22;
        bus.A1 = 5'd7;
        cycle();
        idle();
        #1;
        check("collision_rd1", bus.RD1, 32'h22);

        // Scoreboard: issue sets, load writeback clears, issue+write keeps set.
        bus.ISS = 1'b1; bus.ISS_A = 5'd4; bus.A1 = 5'd4;
        cycle();
        idle();
        #1;
        check("sb_issue_busy1", DW'(bus.BUSY1), 32'h1);
        bus.WE4 = 1'b1; bus.A4 = 5'd4; bus.WD4 = 32'h4444;
        cycle();
        idle();
        #1;
        check("sb_clear_busy1", DW'(bus.BUSY1), 32'h0);
        check("sb_clear_rd1",   bus.RD1, 32'h4444);
        bus.ISS = 1'b1; bus.ISS_A = 5'd4;
        bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h4545;
        cycle();
        idle();
        #1;
        check("sb_set_wins_busy1", DW'(bus.BUSY1), 32'h1);

        // Forwarding: old value 0x77 in reg3 with a pending producer.
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h77;
        bus.ISS = 1'b1; bus.ISS_A = 5'd3;
        cycle();
        idle();
        bus.A1 = 5'd3;
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h55;
        #1;
        check("bypass_rd1_same_cycle",   bus.RD1, BYP ? 32'h55 : 32'h77);
        check("bypass_busy1_same_cycle", DW'(bus.BUSY1), BYP ? 32'h0 : 32'h1);
        cycle();
        idle();
        #1;
        check("bypass_rd1_after",   bus.RD1, 32'h55);
        check("bypass_busy1_after", DW'(bus.BUSY1), 32'h0);

        // Randomized phase; addresses biased into a small window so that
        // collisions, forwarding and issue/write overlaps occur often.
        for (int n = 0; n < 3000; n++) begin
            cycle();
            bus.A1    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.A2    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.WE3   = $urandom_range(0, 1) == 1;
            bus.A3    = AW'($urandom_range(0, 7));
            bus.WD3   = $urandom;
            bus.WE4   = $urandom_range(0, 2) == 0;
            bus.A4    = AW'($urandom_range(0, 7));
            bus.WD4   = $urandom;
            bus.ISS   = $urandom_range(0, 1) == 1;
            bus.ISS_A = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) reset_pulse();
        end

        idle();
        cycle();
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_2w

// File: doc/reg_file_2w.md
Name: reg_file_2w

Overview:
Parametrised successor to the single-write MIPS register file, with 2 combinational read ports and 2 clocked write ports (ALU writeback and load writeback).
Adds a per-register busy scoreboard, so decode can detect RAW hazards on pending producers.
Sits between decode (reads, issue) and the two writeback stages.
Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all registers and busy bits
A1  in  ADDR_W  read port 1 address
A2  in  ADDR_W  read port 2 address
RD1  out  DATA_W  read data 1 (combinational)
RD2  out  DATA_W  read data 2 (combinational)
BUSY1  out  1  register at A1 has a pending producer
BUSY2  out  1  register at A2 has a pending producer
WE3  in  1  write enable, port 3 (ALU writeback)
A3  in  ADDR_W  write address, port 3
WD3  in  DATA_W  write data, port 3
WE4  in  1  write enable, port 4 (load writeback)
A4  in  ADDR_W  write address, port 4
WD4  in  DATA_W  write data, port 4
ISS  in  1  issue strobe: mark destination busy
ISS_A  in  ADDR_W  destination register of the issued instruction

Behaviour:
- Clock and reset: single clock domain (clk); reset is asynchronous and active-high.
- Reset, asserted at any time including mid-write:
  - all registers immediately go to RESET_VAL; register 0 always reads 0;
  - all busy bits go to 0; RD1, RD2, BUSY1 and BUSY2 reflect this combinationally.
- Reset dominates any write or issue in the same cycle.
- Writes:
  - a register updates on the rising edge when its WEx=1 and Ax!=0;
  - writes to address 0 are discarded;
  - WEx=0 leaves storage unchanged whatever Ax and WDx are.
- Dual write to the same address in one cycle: port 4 wins (load result is the younger producer); port 3 data is dropped.
- Reads:
  - RD1 = reg[A1] and RD2 = reg[A2], combinational with zero-cycle latency;
  - A1=0 or A2=0 returns 0.
- Scoreboard, one busy bit per register:
  - set on the rising edge when ISS=1 and ISS_A!=0;
  - cleared on the rising edge by any completed write (WE3 or WE4) to that address;
  - if issue and write hit the same address in one cycle, set wins, so busy stays 1 for the new producer;
  - busy[0] is constantly 0;
  - BUSY1 = busy[A1] and BUSY2 = busy[A2], combinational.
- A write to a non-busy register is legal: it updates data and busy stays 0.
- No widening or sign handling: data is stored bit-exact at DATA_W.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined:
  - same-cycle write-to-read forwarding: if WEx=1 and Ax==A1 (nonzero), RD1 returns WDx in that cycle, port 4 taking priority over port 3; RD2 likewise;
  - BUSY1 and BUSY2 read 0 when a same-cycle write to that address is present and no same-cycle issue targets it.
- Undefined: reads return the stored value until the edge after the write, and busy reflects stored state only.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_W and ADDR_W;
  - REG_ZERO address constant;
  - write-port priority constant (PORT4_WINS).
- One sub-module, reg_scoreboard: busy-bit vector with set/clear priority and the two busy read muxes, parametrised by ADDR_W.
- The storage array and read muxes stay in reg_file_2w.

Test Plan:
- Reset clear: preload reg5=0xDEADBEEF, then pulse reset between edges. Required: RD1 (A1=5) reads 0 immediately, before the next edge, and BUSY1=0.
- Single write: WE3=1, A3=2, WD3=9 for one edge, then WE3=0 with WD3=6, A3=6. Required: RD1 (A1=2)=9 and RD2 (A2=6)=0.
- Zero register: WE3=1, A3=0, WD3=0x1234. Required: RD1 (A1=0)=0 on every following cycle.
- Write collision: WE3=1 and WE4=1, both to address 7, with WD3=0x11 and WD4=0x22. Required: reg7 reads 0x22.
- Scoreboard sequence:
  - ISS=1, ISS_A=4 → BUSY1 (A1=4)=1 after the edge;
  - WE4=1, A4=4 → BUSY1=0 after the edge;
  - ISS with ISS_A=4 together with WE3 to A3=4 → BUSY1 stays 1.
- Bypass: with REG_FILE_BYPASS_EN, WE3=1, A3=3, WD3=0x55 and A1=3. Required: RD1=0x55 in the same cycle; without the macro RD1 holds the old value until after the edge.
